// File: rtl/serial_adder_ctrl_if.sv
// Handshake and result bundle for the bit-serial adder controller.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell reused LSB-first over WIDTH cycles,
// with a registered carry and a one-cycle done pulse on completion.
module fadder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);
  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_ctrl_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;
  logic             fa_s, fa_c;

  fadder u_fa (
    .a_i   (a_q[0]),
    .b_i   (b_q[0]),
    .cin_i (carry_q),
    .sum_o (fa_s),
    .cout_o(fa_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_c;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // carry_q is the carry into the MSB on this last step
          sum_d   = res_d;
          cout_d  = fa_c;
          ovf_d   = carry_q ^ fa_c;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: ;
    endcase
    // a start in IDLE or DONE takes priority over returning to IDLE
    if (bus.start && state_q != RUN) begin
      a_d     = bus.a;
      b_d     = bus.b;
      carry_d = bus.cin;
      cnt_d   = '0;
      state_d = RUN;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: vector table, corner sequences,
// and random operations checked against an arithmetic reference.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();
  serial_adder_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  logic [W-1:0] m_sum;
  logic         m_cout, m_ovf;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // {ovf, cout, sum} from plain unsigned and signed integer arithmetic
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
    longint u, sa, sb, s;
    logic   o;
    u  = longint'(a) + longint'(b) + longint'(c);
    sa = a[W-1] ? longint'(a) - (longint'(1) << W) : longint'(a);
    sb = b[W-1] ? longint'(b) - (longint'(1) << W) : longint'(b);
    s  = sa + sb + longint'(c);
    o  = (s > (longint'(1) << (W-1)) - 1) || (s < -(longint'(1) << (W-1)));
    return {o, u[W], u[W-1:0]};
  endfunction

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                    input logic [W-1:0] es, input logic ec, input logic eo,
                    input string name, input int inject_at);
    int cyc;
    bit busy_bad, stable_bad, extra_done;
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.cin = c;
    @(negedge clk);
    bus.start = 1'b0; bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
    cyc = 1; busy_bad = 0; stable_bad = 0;
    while (!bus.done && cyc <= W + 4) begin
      if (!bus.busy) busy_bad = 1;
      if ({bus.ovf, bus.cout, bus.sum} !== {m_ovf, m_cout, m_sum}) stable_bad = 1;
      if (cyc == inject_at) begin
        bus.start = 1'b1; bus.a = W'($urandom); bus.b = W'($urandom);
      end else bus.start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({name, " done latency"}, 64'(cyc), 64'(W + 1));
    check({name, " busy during run"}, 64'(busy_bad), 64'd0);
    check({name, " outputs stable in run"}, 64'(stable_bad), 64'd0);
    check({name, " busy in done cycle"}, 64'(bus.busy), 64'd0);
    check({name, " result"}, 64'({bus.ovf, bus.cout, bus.sum}), 64'({eo, ec, es}));
    m_sum = es; m_cout = ec; m_ovf = eo;
    @(negedge clk);
    check({name, " done one cycle"}, 64'(bus.done), 64'd0);
    if (inject_at >= 0) begin
      extra_done = 0;
      repeat (W + 2) begin
        @(negedge clk);
        if (bus.done) extra_done = 1;
      end
      check({name, " no second done"}, 64'(extra_done), 64'd0);
    end
  endtask

  initial begin
    vec_t vt[$];
    logic [W-1:0] sweep[4];
    logic [W+1:0] e;
    logic [W-1:0] ra, rb;
    logic rc;
    bit   flag;
    int   inj;

    vt.push_back('{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1});
    vt.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0});
    vt.push_back('{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1});
    sweep[0] = 8'h00; sweep[1] = 8'h01; sweep[2] = 8'h80; sweep[3] = 8'hFF;
    foreach (sweep[i]) foreach (sweep[j]) for (int c = 0; c < 2; c++) begin
      e = ref_add(sweep[i], sweep[j], 1'(c));
      vt.push_back('{sweep[i], sweep[j], 1'(c), e[W-1:0], e[W], e[W+1]});
    end

    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    rst = 1'b1;
    m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs", 64'({bus.busy, bus.done, bus.cout, bus.ovf, bus.sum}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle after reset", 64'({bus.busy, bus.done}), 64'd0);

    foreach (vt[i])
      op(vt[i].a, vt[i].b, vt[i].cin, vt[i].sum, vt[i].cout, vt[i].ovf,
         $sformatf("vec%0d", i), -1);

    // start pulse 3 cycles into RUN must be ignored
    op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, "ignore start", 3);

    // start held high: back-to-back adds, done every W+1 cycles
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0;
    for (int cyc = 1; cyc <= 3 * (W + 1); cyc++) begin
      @(negedge clk);
      flag = (cyc % (W + 1) == 0);
      check("held start done", 64'(bus.done), 64'(flag));
      check("held start busy", 64'(bus.busy), 64'(!flag));
      if (flag) begin
        check("held start result", 64'({bus.ovf, bus.cout, bus.sum}), 64'h030);
        if (cyc == 3 * (W + 1)) bus.start = 1'b0;
      end
    end
    m_sum = 8'h30; m_cout = 1'b0; m_ovf = 1'b0;
    @(negedge clk);
    check("held start back to idle", 64'({bus.busy, bus.done}), 64'd0);

    // reset during RUN cycle 4 aborts the add
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55; bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("busy before abort", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    check("abort outputs", 64'({bus.busy, bus.done, bus.cout, bus.ovf, bus.sum}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
    flag = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (bus.done || bus.busy) flag = 1;
    end
    check("no activity after abort", 64'(flag), 64'd0);
    op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, "after abort", -1);

    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, W - 1)) : -1;
      e = ref_add(ra, rb, rc);
      op(ra, rb, rc, e[W-1:0], e[W], e[W+1], $sformatf("rand%0d", n), inj);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial addition controller that time-shares a single 1-bit full adder cell (FAdder: a, b, cin -> sum, cout) to add two WIDTH-bit operands LSB-first, one bit per clock. It latches operands on a start handshake, sequences the cell for WIDTH cycles with a registered carry, and presents sum, carry-out and signed overflow with a one-cycle done pulse. It is the area-minimal alternative to a ripple chain of WIDTH full adders in the adders library.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous active-high reset
start  input  1  request; sampled only when the block is idle or in its done cycle
a  input  WIDTH  operand A, sampled on the accepted start edge
b  input  WIDTH  operand B, sampled on the accepted start edge
cin  input  1  initial carry-in, sampled on the accepted start edge
busy  output  1  high while a serial add is in progress
done  output  1  one-cycle pulse: result outputs just updated
sum  output  WIDTH  registered result; holds until next completion
cout  output  1  registered final carry-out
ovf  output  1  registered signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Clock is clk; reset is rst, asynchronous, active-high. The async assert forces all state and outputs; release is synchronous to clk.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, internal shift registers, bit counter and carry register = 0.
- Datapath:
  - One FAdder instance. Its a/b inputs are bit 0 of the A/B shift registers; its cin is the carry register.
  - Each RUN cycle: A/B shift right by 1; the FAdder sum shifts into the MSB of the result shift register (right shift); carry register <= FAdder cout.
- Bit counter: $clog2(WIDTH) bits, counts 0..WIDTH-1.
- States:
  - IDLE: busy=0. If start=1, latch a, b, cin (into carry register), clear counter, go to RUN.
  - RUN: busy=1. Process one bit per cycle. When counter==WIDTH-1, process the final bit and, on the same edge, load sum from the completed result shift register. Also on that edge: cout <= FAdder cout, ovf <= carry register (carry into MSB) XOR FAdder cout. Go to DONE. Otherwise increment counter.
  - DONE: done=1, busy=0, exactly one cycle. If start=1, accept a new operation exactly as in IDLE and go to RUN. Otherwise go to IDLE.
- Latency: start accepted at edge k. Bits processed at edges k+1..k+WIDTH. done is high in the cycle following edge k+WIDTH. Throughput is one add per WIDTH+1 cycles with back-to-back starts.
- start in RUN is ignored: no latch, no queue, no error.
- Operand changes after the accepting edge have no effect.
- sum/cout/ovf change only on the completion edge and are stable at all other times, including during RUN.
- Reset mid-RUN aborts the operation: outputs return to 0, no done pulse, block returns to IDLE. The first start after release is serviced normally.
- Arithmetic is modulo 2^WIDTH. {cout,sum} == a + b + cin, unsigned.

Test Plan:
- WIDTH=8; reset, then start with a=0x5A, b=0x3C, cin=0 -> busy high 8 cycles, done pulse at cycle 9, sum=0x96, cout=0, ovf=1.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
- Exhaustive 1-bit-slice check: a and b each swept over {0x00, 0x01, 0x80, 0xFF}, cin over {0,1} (32 operations) -> {cout,sum} equals a+b+cin for every case; ovf matches the signed rule.
- Pulse start again 3 cycles into a RUN with different operands -> ignored; result reflects the first operands only, single done pulse.
- Hold start=1 continuously with a=0x10, b=0x20, cin=0 -> done every 9 cycles, sum=0x30 each time, busy low only in done cycles.
- Assert rst at RUN cycle 4 of a=0xAA+0x55 -> sum=0, cout=0, ovf=0, no done. Then start 0x01+0x01 -> sum=0x02 after normal latency.
